// File: rtl/tau_pkg.sv
// Shared ALU-interface types: mode codes, flag positions,
// branch condition codes, sequencer states and per-op control.
package tau_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_CMP  = 4'd2,
        OP_TEST = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ADD  = 4'd6,
        OP_ADC  = 4'd7,
        OP_SUB  = 4'd8,
        OP_SBB  = 4'd9,
        OP_MUL  = 4'd10,
        OP_AND  = 4'd11,
        OP_OR   = 4'd12,
        OP_XOR  = 4'd13,
        OP_NOT  = 4'd14,
        OP_CLRF = 4'd15
    } alu_mode_e;

    localparam int FLAG_ZERO     = 7;
    localparam int FLAG_SIGN     = 6;
    localparam int FLAG_CARRY    = 5;
    localparam int FLAG_OVERFLOW = 4;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_S      = 3'd5,
        COND_O      = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic       writes_rf;
        logic       clr_flags;
        logic [7:0] flag_mask;
    } op_ctl_t;

    localparam logic [7:0] MASK_NONE = 8'h00;
    localparam logic [7:0] MASK_Z    = 8'h80;
    localparam logic [7:0] MASK_ZSCO = 8'hF0;

    // Indexed by mode code 0..15.
    localparam op_ctl_t OP_CTL [16] = '{
        '{1'b0, 1'b0, MASK_NONE},
        '{1'b1, 1'b0, MASK_NONE},
        '{1'b0, 1'b0, MASK_ZSCO},
        '{1'b0, 1'b0, MASK_ZSCO},
        '{1'b1, 1'b0, MASK_NONE},
        '{1'b1, 1'b0, MASK_NONE},
        '{1'b1, 1'b0, MASK_ZSCO},
        '{1'b1, 1'b0, MASK_ZSCO},
        '{1'b1, 1'b0, MASK_ZSCO},
        '{1'b1, 1'b0, MASK_ZSCO},
        '{1'b1, 1'b0, MASK_Z},
        '{1'b1, 1'b0, MASK_ZSCO},
        '{1'b1, 1'b0, MASK_ZSCO},
        '{1'b1, 1'b0, MASK_ZSCO},
        '{1'b1, 1'b0, MASK_ZSCO},
        '{1'b0, 1'b1, MASK_NONE}
    };

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational branch-condition check against the flags register.
// Shared between the sequencer and the branch unit.
module flag_cond_eval
    import tau_pkg::*;
(
    input  logic [2:0] cond_sel_i,
    input  logic [7:0] flags_i,
    output logic       cond_true_o
);

    logic unused_low;
    assign unused_low = ^flags_i[3:0];

    always_comb begin
        cond_true_o = 1'b0;
        unique case (cond_e'(cond_sel_i))
            COND_ALWAYS: cond_true_o = 1'b1;
            COND_Z:      cond_true_o = flags_i[FLAG_ZERO];
            COND_NZ:     cond_true_o = !flags_i[FLAG_ZERO];
            COND_C:      cond_true_o = flags_i[FLAG_CARRY];
            COND_NC:     cond_true_o = !flags_i[FLAG_CARRY];
            COND_S:      cond_true_o = flags_i[FLAG_SIGN];
            COND_O:      cond_true_o = flags_i[FLAG_OVERFLOW];
            COND_NEVER:  cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one decoded ALU op every four cycles: read operands,
// drive the ALU, capture result/flags, write back.
module alu_sequencer
    import tau_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int REG_COUNT = 8,
    localparam int RA_W     = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [RA_W-1:0]      req_dst,
    input  logic [RA_W-1:0]      req_src_a,
    input  logic [RA_W-1:0]      req_src_b,
    input  logic                 req_imm_en,
    input  logic [WORD_SIZE-1:0] req_imm,
    output logic [RA_W-1:0]      rf_rd_addr_a,
    output logic [RA_W-1:0]      rf_rd_addr_b,
    input  logic [WORD_SIZE-1:0] rf_rd_data_a,
    input  logic [WORD_SIZE-1:0] rf_rd_data_b,
    output logic [WORD_SIZE-1:0] alu_input_A,
    output logic [WORD_SIZE-1:0] alu_input_B,
    output logic [3:0]           alu_mode_select,
    input  logic [WORD_SIZE-1:0] alu_output_C,
    input  logic [7:0]           alu_flags,
    output logic                 rf_wr_en,
    output logic [RA_W-1:0]      rf_wr_addr,
    output logic [WORD_SIZE-1:0] rf_wr_data,
    output logic [7:0]           flags_q,
    input  logic [2:0]           cond_sel,
    output logic                 cond_true
);

    seq_state_e           state_q;
    alu_mode_e            op_q;
    logic [RA_W-1:0]      dst_q;
    logic                 imm_en_q;
    logic [WORD_SIZE-1:0] imm_q;
    logic [WORD_SIZE-1:0] result_q;
    logic [RA_W-1:0]      rd_addr_a_q;
    logic [RA_W-1:0]      rd_addr_b_q;
    logic                 wr_en_q;
    logic [RA_W-1:0]      wr_addr_q;

    op_ctl_t    ctl;
    logic [7:0] flags_d;
    logic       exec;

    assign ctl  = OP_CTL[op_q];
    assign exec = (state_q == EXEC);

    // Masked merge keeps flags the op does not own; low nibble stays 0.
    always_comb begin
        flags_d = (flags_q & ~ctl.flag_mask) | (alu_flags & ctl.flag_mask);
        if (ctl.clr_flags) begin
            flags_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            dst_q       <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= '0;
            result_q    <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            flags_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= alu_mode_e'(req_op);
                        dst_q       <= req_dst;
                        imm_en_q    <= req_imm_en;
                        imm_q       <= req_imm;
                        rd_addr_a_q <= req_src_a;
                        rd_addr_b_q <= req_src_b;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    state_q <= EXEC;
                end
                EXEC: begin
                    result_q  <= alu_output_C;
                    flags_q   <= flags_d;
                    wr_en_q   <= ctl.writes_rf;
                    wr_addr_q <= dst_q;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    wr_en_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign rf_rd_addr_a    = rd_addr_a_q;
    assign rf_rd_addr_b    = rd_addr_b_q;
    assign alu_input_A     = exec ? rf_rd_data_a : '0;
    assign alu_input_B     = !exec ? '0 : (imm_en_q ? imm_q : rf_rd_data_b);
    assign alu_mode_select = exec ? op_q : OP_NOP;
    assign rf_wr_en        = wr_en_q;
    assign rf_wr_addr      = wr_addr_q;
    assign rf_wr_data      = result_q;

    flag_cond_eval u_cond (
        .cond_sel_i  (cond_sel),
        .flags_i     (flags_q),
        .cond_true_o (cond_true)
    );

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issuing side of the ALU interface; sits between the decode stage and the ALU/register file.
- Accepts one decoded ALU operation per valid/ready handshake and reads operands from the register file.
- Drives the ALU operand and mode inputs for one cycle, then captures result and flags into registers.
- Writes the result back, owns the architectural flags register, and evaluates branch conditions from it.

Parameters:
- WORD_SIZE, 8, datapath width of operands, result and immediate.
- REG_COUNT, 8, number of register-file entries; RA_W = $clog2(REG_COUNT) is the register address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operation request valid.
- req_ready  out  1  sequencer can accept a request; equals (state==IDLE).
- req_op  in  4  ALU mode code 0-15, same encoding as the ALU mode_select.
- req_dst  in  RA_W  destination register.
- req_src_a  in  RA_W  operand A register.
- req_src_b  in  RA_W  operand B register.
- req_imm_en  in  1  use req_imm as operand B instead of req_src_b.
- req_imm  in  WORD_SIZE  immediate operand.
- rf_rd_addr_a  out  RA_W  register-file read address A.
- rf_rd_addr_b  out  RA_W  register-file read address B.
- rf_rd_data_a  in  WORD_SIZE  read data A; synchronous read, valid one cycle after the address.
- rf_rd_data_b  in  WORD_SIZE  read data B; same timing as A.
- alu_input_A  out  WORD_SIZE  ALU operand A.
- alu_input_B  out  WORD_SIZE  ALU operand B.
- alu_mode_select  out  4  ALU mode.
- alu_output_C  in  WORD_SIZE  ALU result.
- alu_flags  in  8  ALU flags: [7] Z, [6] S, [5] C, [4] O.
- rf_wr_en  out  1  register-file write strobe, one-cycle pulse.
- rf_wr_addr  out  RA_W  write address.
- rf_wr_data  out  WORD_SIZE  write data.
- flags_q  out  8  architectural flags; bits [3:0] always 0.
- cond_sel  in  3  condition code: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 S, 6 O, 7 never.
- cond_true  out  1  combinational evaluation of cond_sel against flags_q.

Behaviour:
Reset and idle:
- Reset (rst high at a clock edge) forces state IDLE and clears the request latch, result register, flags_q and every registered output to 0.
- req_ready is combinationally high in IDLE. A handshake is ignored in any cycle where rst is high.
- Reset mid-operation drops the pending op: no write, flags_q becomes 0.
- Outside EXEC: alu_mode_select=0 (ALU "do nothing"), alu_input_A/B=0.

FSM, one op occupies 4 cycles:
- IDLE: on req_valid&&req_ready, latch all req_* fields, drive rf_rd_addr_a/b from req_src_a/b, go to READ.
- READ: wait one cycle for register-file read data; go to EXEC.
- EXEC:
  - alu_input_A = rf_rd_data_a.
  - alu_input_B = req_imm_en ? latched imm : rf_rd_data_b.
  - alu_mode_select = latched op.
  - At the clock edge, capture alu_output_C into the result register and update flags_q per the mask below. Go to WRITE.
- WRITE: rf_wr_en=1 for exactly this cycle if the op writes; rf_wr_addr=dst, rf_wr_data=result. Go to IDLE.
- Latency: with the request accepted at edge 0, flags_q updates at edge 2 and rf_wr_en is high during cycle 3.
- Back-to-back rate is 1 op per 4 cycles. The next op's register read happens after the prior write, so no forwarding is needed.

Write and flag rules per op:
- 0 NOP: no write, flags unchanged.
- 1 MOV: write, flags unchanged.
- 2 CMP, 3 TEST: no write; Z, S, C, O taken from alu_flags.
- 4 SHL, 5 SHR: write, flags unchanged.
- 6-9 ADD/ADC/SUB/SBB and 11-14 AND/OR/XOR/NOT: write; Z, S, C, O taken from alu_flags.
- 10 MUL: write; Z only.
- 15 CLRF: no write; flags_q cleared to 0.
- Results are truncated to WORD_SIZE; the sequencer never widens or alters ALU results.
- req_dst is honoured for any index, including 0.

Decomposition:
- tau_pkg holds:
  - alu_mode_e, the 16 mode codes.
  - Flag bit indices FLAG_ZERO=7, FLAG_SIGN=6, FLAG_CARRY=5, FLAG_OVERFLOW=4.
  - cond_e, the condition codes.
  - seq_state_e: IDLE, READ, EXEC, WRITE.
  - A per-op constant table giving writes_rf and the flag-update mask.
- One sub-module, flag_cond_eval: combinational cond_sel plus flags_q to cond_true, reusable by the branch unit.

Test Plan:
1. Reset, then ADD with r1=0x7F, r2=0x01, dst r3 -> rf_wr_en in cycle 3 with r3=0x80; flags_q=0x50 (S, O).
2. CMP with r1=0x05, imm=0x05 -> no rf_wr_en; flags_q Z=1, C=0; cond_sel=1 gives cond_true=1, cond_sel=2 gives 0.
3. SHL r1=0x01 by imm 3, following an op that set C -> writes 0x08; flags_q unchanged.
4. req_valid held high for 3 back-to-back ops -> req_ready high only in IDLE cycles; accepts at cycles 0, 4, 8; each write is correct.
5. rst asserted during EXEC of a SUB -> no rf_wr_en; flags_q=0; req_ready high the cycle after reset releases.
6. CLRF after flags_q=0xF0 -> flags_q=0x00, no write; MUL 0x10*0x10 -> writes 0x00 and sets only Z.
